// File: rtl/approx_mul_rr_scheduler_if.sv
// approx_mul_rr_scheduler_if: requester, multiplier and response channels of the
// shared-multiplier scheduler; slave is the scheduler side, master the environment.
interface approx_mul_rr_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ*8-1:0] req_x;
    logic [NUM_REQ*8-1:0] req_y;
    logic [7:0]           mul_x;
    logic [7:0]           mul_y;
    logic [15:0]          mul_z;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [15:0]          rsp_z;
    logic [ID_W-1:0]      rsp_id;
    modport slave (
        input  req_valid, req_x, req_y, mul_z, rsp_ready,
        output req_ready, mul_x, mul_y, rsp_valid, rsp_z, rsp_id
    );
    modport master (
        output req_valid, req_x, req_y, mul_z, rsp_ready,
        input  req_ready, mul_x, mul_y, rsp_valid, rsp_z, rsp_id
    );
endinterface

// File: rtl/approx_mul_rr_scheduler.sv
// approx_mul_rr_scheduler: round-robin sharing of one combinational 8x8 multiplier
// across NUM_REQ requesters through an operand stage and a result stage.
module approx_mul_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    approx_mul_rr_scheduler_if.slave bus,
    output logic                busy_o,
    output logic [CNT_W-1:0]    done_cnt_o
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic             s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic [7:0]       x_q, x_d, y_q, y_d;
    logic [ID_W-1:0]  s1_id_q, s1_id_d, rsp_id_q, rsp_id_d, ptr_q, ptr_d;
    logic [15:0]      z_q, z_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ID_W-1:0]  gnt_id, idx;
    logic             gnt_any, s2_free, s1_free, accept, advance, rsp_hs;

    // Scan downward so the candidate closest to the pointer is the last one written.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id = '0;
        idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ID_W'((int'(ptr_q) + k) % NUM_REQ);
            if (bus.req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_id = idx;
            end
        end
    end

    always_comb begin
        s2_free = !s2_valid_q || bus.rsp_ready;
        s1_free = !s1_valid_q || s2_free;
        accept = gnt_any && s1_free && !rst;
        advance = s1_valid_q && s2_free;
        rsp_hs = s2_valid_q && bus.rsp_ready;
        s1_valid_d = accept || (s1_valid_q && !s2_free);
        s2_valid_d = advance || (s2_valid_q && !bus.rsp_ready);
        x_d = accept ? bus.req_x[8*gnt_id +: 8] : x_q;
        y_d = accept ? bus.req_y[8*gnt_id +: 8] : y_q;
        s1_id_d = accept ? gnt_id : s1_id_q;
        ptr_d = accept ? ID_W'((int'(gnt_id) + 1) % NUM_REQ) : ptr_q;
        z_d = advance ? bus.mul_z : z_q;
        rsp_id_d = advance ? s1_id_q : rsp_id_q;
        cnt_d = cnt_q + CNT_W'(rsp_hs);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            x_q <= '0;
            y_q <= '0;
            s1_id_q <= '0;
            ptr_q <= '0;
            z_q <= '0;
            rsp_id_q <= '0;
            cnt_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            x_q <= x_d;
            y_q <= y_d;
            s1_id_q <= s1_id_d;
            ptr_q <= ptr_d;
            z_q <= z_d;
            rsp_id_q <= rsp_id_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.req_ready = accept ? NUM_REQ'(1) << gnt_id : '0;
    assign bus.mul_x = x_q;
    assign bus.mul_y = y_q;
    assign bus.rsp_valid = s2_valid_q;
    assign bus.rsp_z = z_q;
    assign bus.rsp_id = rsp_id_q;
    assign busy_o = s1_valid_q || s2_valid_q;
    assign done_cnt_o = cnt_q;
endmodule

// File: tb/tb_approx_mul_rr_scheduler.sv
// tb_approx_mul_rr_scheduler: vector table, directed corner sequences and a
// randomized run against a transaction-level queue model of the scheduler.
module tb_approx_mul_rr_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    logic [15:0] done_cnt;
    int checks = 0;
    int failures = 0;

    approx_mul_rr_scheduler_if #(.NUM_REQ(4)) bus ();

    approx_mul_rr_scheduler #(.NUM_REQ(4), .CNT_W(16)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .busy_o(busy),
        .done_cnt_o(done_cnt)
    );

    assign bus.mul_z = bus.mul_x * bus.mul_y;

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  rv;
        logic [7:0]  x;
        logic [7:0]  y;
        logic        rr;
        logic [3:0]  er;
        logic        ev;
        logic [15:0] ez;
        logic [1:0]  eid;
        logic [15:0] ec;
    } vec_t;

    typedef struct {
        logic [15:0] z;
        int          id;
        bit          s2;
    } item_t;

    vec_t tbl[12];
    item_t q[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.req_valid = '0;
        bus.req_x = '0;
        bus.req_y = '0;
        bus.rsp_ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic int rr_pick(input logic [3:0] rv, input int ptr);
        for (int k = 0; k < 4; k++)
            if (rv[(ptr + k) % 4]) return (ptr + k) % 4;
        return -1;
    endfunction

    initial begin
        int mptr, mcnt, g, n;
        logic [7:0] mx, my, gx, gy;
        logic [31:0] rx, ry;
        logic [3:0] rv, er;
        logic rr, ev, s1f, s2free, s1free;

        tbl[0]  = '{4'b0001, 8'd3, 8'd5, 1'b1, 4'b0001, 1'b0, 16'd0,  2'd0, 16'd0};
        tbl[1]  = '{4'b0000, 8'd0, 8'd0, 1'b1, 4'b0000, 1'b0, 16'd0,  2'd0, 16'd0};
        tbl[2]  = '{4'b0000, 8'd0, 8'd0, 1'b1, 4'b0000, 1'b1, 16'd15, 2'd0, 16'd0};
        tbl[3]  = '{4'b0000, 8'd0, 8'd0, 1'b1, 4'b0000, 1'b0, 16'd15, 2'd0, 16'd1};
        tbl[4]  = '{4'b0010, 8'd2, 8'd7, 1'b1, 4'b0010, 1'b0, 16'd15, 2'd0, 16'd1};
        tbl[5]  = '{4'b1001, 8'd4, 8'd4, 1'b1, 4'b1000, 1'b0, 16'd15, 2'd0, 16'd1};
        tbl[6]  = '{4'b1001, 8'd5, 8'd5, 1'b1, 4'b0001, 1'b1, 16'd14, 2'd1, 16'd1};
        tbl[7]  = '{4'b0000, 8'd0, 8'd0, 1'b0, 4'b0000, 1'b1, 16'd16, 2'd3, 16'd2};
        tbl[8]  = '{4'b1111, 8'd1, 8'd1, 1'b0, 4'b0000, 1'b1, 16'd16, 2'd3, 16'd2};
        tbl[9]  = '{4'b0000, 8'd0, 8'd0, 1'b1, 4'b0000, 1'b1, 16'd16, 2'd3, 16'd2};
        tbl[10] = '{4'b0000, 8'd0, 8'd0, 1'b1, 4'b0000, 1'b1, 16'd25, 2'd0, 16'd3};
        tbl[11] = '{4'b0000, 8'd0, 8'd0, 1'b1, 4'b0000, 1'b0, 16'd25, 2'd0, 16'd4};

        // reset state, including ready gated while reset is held
        do_reset();
        rst = 1'b1;
        bus.req_valid = 4'b1111;
        #1;
        chk("rst_ready", bus.req_ready, 0);
        bus.req_valid = '0;
        tick();
        rst = 1'b0;
        #1;
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", done_cnt, 0);
        chk("rst_mul_x", bus.mul_x, 0);
        chk("rst_rsp_z", bus.rsp_z, 0);
        chk("rst_rsp_id", bus.rsp_id, 0);

        // single product, pointer order and stall via vector table
        do_reset();
        for (int i = 0; i < 12; i++) begin
            bus.req_valid = tbl[i].rv;
            bus.req_x = {4{tbl[i].x}};
            bus.req_y = {4{tbl[i].y}};
            bus.rsp_ready = tbl[i].rr;
            #1;
            chk($sformatf("vec%0d_ready", i), bus.req_ready, tbl[i].er);
            chk($sformatf("vec%0d_rsp_valid", i), bus.rsp_valid, tbl[i].ev);
            chk($sformatf("vec%0d_rsp_z", i), bus.rsp_z, tbl[i].ez);
            chk($sformatf("vec%0d_rsp_id", i), bus.rsp_id, tbl[i].eid);
            chk($sformatf("vec%0d_cnt", i), done_cnt, tbl[i].ec);
            tick();
        end

        // fairness: all requesters held, back-to-back grants and responses
        do_reset();
        bus.req_valid = 4'b1111;
        bus.req_x = {8'd4, 8'd3, 8'd2, 8'd1};
        bus.req_y = {4{8'd10}};
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            chk($sformatf("fair%0d_ready", c), bus.req_ready, 1 << (c % 4));
            chk($sformatf("fair%0d_rsp_valid", c), bus.rsp_valid, c >= 2);
            if (c >= 2) begin
                chk($sformatf("fair%0d_rsp_id", c), bus.rsp_id, (c - 2) % 4);
                chk($sformatf("fair%0d_rsp_z", c), bus.rsp_z, 10 * ((c - 2) % 4 + 1));
            end
            tick();
        end

        // backpressure: two accepts then stall, release drains both exactly once
        do_reset();
        bus.req_valid = 4'b0100;
        bus.req_x = {4{8'd255}};
        bus.req_y = {4{8'd255}};
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("bp%0d_ready", c), bus.req_ready, c < 2 ? 4'b0100 : 4'b0000);
            chk($sformatf("bp%0d_rsp_valid", c), bus.rsp_valid, c >= 2);
            if (c >= 2) chk($sformatf("bp%0d_rsp_z", c), bus.rsp_z, 65025);
            tick();
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("bpr%0d_rsp_valid", c), bus.rsp_valid, c < 2);
            chk($sformatf("bpr%0d_cnt", c), done_cnt, c);
            tick();
        end

        // reset with both stages full
        do_reset();
        bus.req_valid = 4'b0100;
        bus.req_x = {4{8'd9}};
        bus.req_y = {4{8'd9}};
        tick();
        tick();
        chk("mid_busy_before", busy, 1);
        chk("mid_valid_before", bus.rsp_valid, 1);
        rst = 1'b1;
        #1;
        chk("mid_rsp_valid", bus.rsp_valid, 0);
        chk("mid_busy", busy, 0);
        chk("mid_ready", bus.req_ready, 0);
        chk("mid_mul_x", bus.mul_x, 0);
        chk("mid_rsp_z", bus.rsp_z, 0);
        bus.req_valid = '0;
        tick();
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk($sformatf("post%0d_rsp_valid", c), bus.rsp_valid, 0);
            tick();
        end
        bus.req_valid = 4'b1010;
        #1;
        chk("post_ptr_ready", bus.req_ready, 4'b0010);

        // randomized traffic against the queue model
        do_reset();
        q.delete();
        mptr = 0;
        mcnt = 0;
        mx = '0;
        my = '0;
        for (int c = 0; c < 2000; c++) begin
            rv = 4'($urandom);
            rx = $urandom;
            ry = $urandom;
            rr = $urandom_range(0, 3) != 0;
            bus.req_valid = rv;
            bus.req_x = rx;
            bus.req_y = ry;
            bus.rsp_ready = rr;
            #1;
            ev = q.size() > 0 && q[0].s2;
            s1f = q.size() > 0 && !q[q.size()-1].s2;
            s2free = !ev || rr;
            s1free = !s1f || s2free;
            g = rr_pick(rv, mptr);
            er = (g >= 0 && s1free) ? 4'(1 << g) : 4'b0000;
            chk("rnd_ready", bus.req_ready, er);
            chk("rnd_rsp_valid", bus.rsp_valid, ev);
            if (ev) begin
                chk("rnd_rsp_z", bus.rsp_z, q[0].z);
                chk("rnd_rsp_id", bus.rsp_id, q[0].id);
            end
            chk("rnd_busy", busy, q.size() > 0);
            chk("rnd_cnt", done_cnt, mcnt);
            chk("rnd_mul_x", bus.mul_x, mx);
            chk("rnd_mul_y", bus.mul_y, my);
            if (ev && rr) begin
                void'(q.pop_front());
                mcnt = (mcnt + 1) % 65536;
            end
            if (s1f && s2free) q[q.size()-1].s2 = 1'b1;
            if (er != 0) begin
                gx = rx[8*g +: 8];
                gy = ry[8*g +: 8];
                q.push_back('{16'(gx * gy), g, 1'b0});
                mptr = (g + 1) % 4;
                mx = gx;
                my = gy;
            end
            tick();
        end

        // counter wrap after 65535 handshakes
        do_reset();
        bus.req_valid = 4'b1111;
        bus.rsp_ready = 1'b1;
        n = 0;
        #1;
        for (int c = 0; c < 70000 && n < 65535; c++) begin
            if (bus.rsp_valid) n++;
            tick();
        end
        chk("wrap_count_reached", n, 65535);
        chk("wrap_pre", done_cnt, 65535);
        chk("wrap_valid", bus.rsp_valid, 1);
        tick();
        chk("wrap_zero", done_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
